// File: rtl/mem_arb_pkg.sv
// Shared sizes and response-owner encoding for the unified SRAM arbiter.
package mem_arb_pkg;
  localparam int SRAM_AW = 14;
  localparam int SRAM_DW = 32;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} rsp_owner_e;
endpackage

// File: rtl/sram_arbiter_if.sv
// Fetch port, load/store port and single-port SRAM pins as seen by the arbiter.
interface sram_arbiter_if;
  import mem_arb_pkg::*;

  logic               if_req;
  logic [31:0]        if_addr;
  logic               if_gnt;
  logic               if_rvalid;
  logic [SRAM_DW-1:0] if_rdata;

  logic               ls_req;
  logic               ls_we;
  logic [SRAM_DW-1:0] ls_bweb;
  logic [31:0]        ls_addr;
  logic [SRAM_DW-1:0] ls_wdata;
  logic               ls_gnt;
  logic               ls_rvalid;
  logic [SRAM_DW-1:0] ls_rdata;

  logic               sram_ceb;
  logic               sram_web;
  logic [SRAM_DW-1:0] sram_bweb;
  logic [SRAM_AW-1:0] sram_a;
  logic [SRAM_DW-1:0] sram_di;
  logic [SRAM_DW-1:0] sram_do;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_bweb, ls_addr, ls_wdata, sram_do,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           sram_ceb, sram_web, sram_bweb, sram_a, sram_di
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_bweb, ls_addr, ls_wdata, sram_do,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           sram_ceb, sram_web, sram_bweb, sram_a, sram_di
  );
endinterface

// File: rtl/starve_counter.sv
// Counts consecutive LSU grants taken while fetch waits; at_cap hands the next slot to fetch.
module starve_counter #(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic ls_gnt,
  output logic at_cap
);
  localparam logic [3:0] CAP = 4'(MAX_LS_STREAK);

  logic [3:0] streak_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      streak_cnt <= '0;
    end else if (ls_gnt && streak_cnt != CAP) begin
      streak_cnt <= streak_cnt + 4'd1;
    end
  end

  assign at_cap = (streak_cnt == CAP);
endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between fetch and LSU: combinational grant, LSU-first with bounded fetch starvation.
// Read data returns one cycle after grant; no response backpressure, losers simply retry.
module sram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);
  logic               at_cap;
  logic               if_win;
  logic               ls_win;
  logic               ceb;
  logic               web;
  logic [SRAM_DW-1:0] bweb;
  logic [SRAM_AW-1:0] addr;
  logic [SRAM_DW-1:0] wdata;
  rsp_owner_e         rsp_owner;
  rsp_owner_e         rsp_next;

  // Only word-address bits reach the macro.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:16], bus.if_addr[1:0],
                              bus.ls_addr[31:16], bus.ls_addr[1:0]};

  starve_counter #(.MAX_LS_STREAK(MAX_LS_STREAK)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .if_gnt (if_win),
    .ls_gnt (ls_win),
    .at_cap (at_cap)
  );

  // Grants are held off while rst is high so the macro stays idle through reset.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (!rst) begin
      if (bus.if_req && (!bus.ls_req || at_cap)) begin
        if_win = 1'b1;
      end else if (bus.ls_req) begin
        ls_win = 1'b1;
      end
    end
  end

  always_comb begin
    ceb   = 1'b1;
    web   = 1'b1;
    bweb  = '1;
    addr  = '0;
    wdata = '0;
    if (if_win) begin
      ceb  = 1'b0;
      addr = bus.if_addr[SRAM_AW+1:2];
    end else if (ls_win) begin
      ceb   = 1'b0;
      web   = ~bus.ls_we;
      bweb  = bus.ls_we ? bus.ls_bweb : '1;
      addr  = bus.ls_addr[SRAM_AW+1:2];
      wdata = bus.ls_wdata;
    end
  end

  always_comb begin
    rsp_next = OWN_NONE;
    if (if_win) begin
      rsp_next = OWN_IF;
    end else if (ls_win && !bus.ls_we) begin
      rsp_next = OWN_LS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_owner <= OWN_NONE;
    end else begin
      rsp_owner <= rsp_next;
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.ls_gnt    = ls_win;
  assign bus.sram_ceb  = ceb;
  assign bus.sram_web  = web;
  assign bus.sram_bweb = bweb;
  assign bus.sram_a    = addr;
  assign bus.sram_di   = wdata;

  assign bus.if_rvalid = (rsp_owner == OWN_IF);
  assign bus.ls_rvalid = (rsp_owner == OWN_LS);
  assign bus.if_rdata  = bus.sram_do;
  assign bus.ls_rdata  = bus.sram_do;
endmodule
